// File: rtl/matvec_param.sv
// ---------------------------------------------------------------------------
// MatvecParam : streaming K x K signed matrix times K-element vector engine.
//
// Elements arrive one per handshake on the input port. A group optionally
// starts with K*K matrix elements (flagged by i_new_matrix on the group's
// first element), followed by K vector elements. The stored matrix is reused
// by later vector-only groups. After the last vector element the block runs
// one multiply-accumulate per cycle per row and presents y[0]..y[K-1] in
// order on the output port, stalling the next row while a result waits.
//
// Configuration macro:
//   MATVEC_SAT_EN  defined   -> results clamp to the signed OW range
//                  undefined -> results wrap (low OW bits of the accumulator)
//
// Parameters:
//   K   matrix dimension (2..16)
//   IW  signed input element width
//   OW  signed output element width (OW >= 2*IW)
//
// Ports:
//   i_clk           clock, all state changes on the rising edge
//   i_reset         synchronous active-high reset
//   i_input_valid   element on i_input_data / i_new_matrix is valid
//   o_input_ready   block accepts an element this cycle
//   i_input_data    signed matrix or vector element
//   i_new_matrix    on a group's first element: group starts with a matrix
//   o_output_valid  o_output_data holds a result element
//   i_output_ready  consumer takes o_output_data this cycle
//   o_output_data   signed result element y[r], zero when not valid
// ---------------------------------------------------------------------------
module matvec_param #(
  parameter int K  = 8,
  parameter int IW = 14,
  parameter int OW = 28
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_input_valid,
  output logic                 o_input_ready,
  input  logic signed [IW-1:0] i_input_data,
  input  logic                 i_new_matrix,
  output logic                 o_output_valid,
  input  logic                 i_output_ready,
  output logic signed [OW-1:0] o_output_data
);

  localparam int RW = $clog2(K);
  // Accumulator holds a sum of K full-precision products without overflow.
  localparam int AW = 2 * IW + $clog2(K);
  localparam int EW = (AW > OW) ? AW : OW;
  localparam logic [RW-1:0] LAST = RW'(K - 1);

  typedef enum logic [1:0] {
    LOAD_M  = 2'd0,
    LOAD_X  = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } stateT;

  stateT                r_state;
  stateT                w_nextState;
  logic signed [IW-1:0] r_mat [K][K];
  logic signed [IW-1:0] r_vec [K];
  logic [RW-1:0]        r_row;
  logic [RW-1:0]        r_col;
  logic signed [AW-1:0] r_acc;
  logic signed [OW-1:0] r_outData;

  logic                   w_inXfer;
  logic                   w_outXfer;
  logic                   w_startMatrix;
  logic signed [2*IW-1:0] w_mOp;
  logic signed [2*IW-1:0] w_xOp;
  logic signed [2*IW-1:0] w_prod;
  logic signed [AW-1:0]   w_sum;
  logic signed [EW-1:0]   w_sumExt;
  logic signed [OW-1:0]   w_result;

  // Handshake qualifiers. The new-matrix flag only means something on the
  // first element seen in LOAD_X, so it is masked everywhere else.
  always_comb begin
    w_inXfer      = i_input_valid && o_input_ready;
    w_outXfer     = o_output_valid && i_output_ready;
    w_startMatrix = (r_state == LOAD_X) && (r_col == '0) && i_new_matrix;
  end

  // One MAC per cycle: operands are sign-extended to full product width so
  // the product is exact, then sign-extended again into the accumulator.
  always_comb begin
    w_mOp    = {{IW{r_mat[r_row][r_col][IW-1]}}, r_mat[r_row][r_col]};
    w_xOp    = {{IW{r_vec[r_col][IW-1]}}, r_vec[r_col]};
    w_prod   = w_mOp * w_xOp;
    w_sum    = r_acc + {{(AW - 2 * IW){w_prod[2*IW-1]}}, w_prod};
    w_sumExt = EW'(w_sum);
  end

`ifdef MATVEC_SAT_EN
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

  // Clamp the finished row sum into the signed output range.
  always_comb begin
    if (w_sumExt > SAT_MAX) begin
      w_result = {1'b0, {(OW - 1){1'b1}}};
    end else if (w_sumExt < SAT_MIN) begin
      w_result = {1'b1, {(OW - 1){1'b0}}};
    end else begin
      w_result = w_sumExt[OW-1:0];
    end
  end
`else
  logic w_unusedSumBits;

  // Two's-complement wrap: keep the low OW bits, the rest is dropped.
  always_comb begin
    w_result        = w_sumExt[OW-1:0];
    w_unusedSumBits = ^w_sumExt;
  end
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= LOAD_X;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. DRAIN is where a finished row waits for the consumer;
  // the next row is only computed after that result has been taken.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      LOAD_X: begin
        if (w_inXfer) begin
          if (w_startMatrix) begin
            w_nextState = LOAD_M;
          end else if (r_col == LAST) begin
            w_nextState = COMPUTE;
          end
        end
      end
      LOAD_M: begin
        if (w_inXfer && (r_row == LAST) && (r_col == LAST)) begin
          w_nextState = LOAD_X;
        end
      end
      COMPUTE: begin
        if (r_col == LAST) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (w_outXfer) begin
          w_nextState = (r_row == LAST) ? LOAD_X : COMPUTE;
        end
      end
      default: w_nextState = LOAD_X;
    endcase
  end

  // Outputs decoded from state; the output register is cleared whenever
  // its result is consumed, so it reads zero while not valid.
  always_comb begin
    o_input_ready  = (r_state == LOAD_M) || (r_state == LOAD_X);
    o_output_valid = (r_state == DRAIN);
    o_output_data  = r_outData;
  end

  // Datapath: element storage, row/column counters, accumulator and the
  // output register. Row/column double as the load counters, so LOAD_X
  // "count 0" is simply row = col = 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          r_mat[i][j] <= '0;
        end
        r_vec[i] <= '0;
      end
      r_row     <= '0;
      r_col     <= '0;
      r_acc     <= '0;
      r_outData <= '0;
    end else begin
      case (r_state)
        LOAD_X: begin
          if (w_inXfer) begin
            if (w_startMatrix) begin
              r_mat[0][0] <= i_input_data;
              r_row       <= '0;
              r_col       <= RW'(1);
            end else begin
              r_vec[r_col] <= i_input_data;
              if (r_col == LAST) begin
                r_col <= '0;
                r_row <= '0;
                r_acc <= '0;
              end else begin
                r_col <= r_col + RW'(1);
              end
            end
          end
        end
        LOAD_M: begin
          if (w_inXfer) begin
            r_mat[r_row][r_col] <= i_input_data;
            if (r_col == LAST) begin
              r_col <= '0;
              r_row <= (r_row == LAST) ? '0 : r_row + RW'(1);
            end else begin
              r_col <= r_col + RW'(1);
            end
          end
        end
        COMPUTE: begin
          if (r_col == LAST) begin
            r_outData <= w_result;
            r_col     <= '0;
            r_acc     <= '0;
          end else begin
            r_acc <= w_sum;
            r_col <= r_col + RW'(1);
          end
        end
        DRAIN: begin
          if (w_outXfer) begin
            r_outData <= '0;
            r_col     <= '0;
            r_row     <= (r_row == LAST) ? '0 : r_row + RW'(1);
          end
        end
        default: begin
          r_col <= '0;
          r_row <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_param.sv
// ---------------------------------------------------------------------------
// tb_matvec_param : scoreboard bench for matvec_param.
//
// Instance A (K=2, IW=4, OW=8) gets directed groups, mid-load and mid-drain
// resets and 1000 random groups with random valid/ready. Instance B uses the
// default parameters for the all-minimum-value case. Expected results come
// from a plain dot-product model plus a wrap/clamp helper that follows
// MATVEC_SAT_EN.
// ---------------------------------------------------------------------------
module tb_matvec_param;

  localparam int K   = 2;
  localparam int IW  = 4;
  localparam int OW  = 8;
  localparam int BK  = 8;
  localparam int BIW = 14;
  localparam int BOW = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 aReset;
  logic                 aInputValid;
  logic                 aInputReady;
  logic [IW-1:0]        aInputData;
  logic                 aNewMatrix;
  logic                 aOutputValid;
  logic                 aOutputReady;
  logic signed [OW-1:0] aOutputData;

  logic                  bReset;
  logic                  bInputValid;
  logic                  bInputReady;
  logic [BIW-1:0]        bInputData;
  logic                  bNewMatrix;
  logic                  bOutputValid;
  logic                  bOutputReady;
  logic signed [BOW-1:0] bOutputData;

  int     checkCount = 0;
  int     passCount  = 0;
  longint expQ[$];
  longint bQ[$];
  int     refMat[K*K];
  int     stimM[K*K];
  int     stimX[K];
  int     readyMode = 0;
  bit     held = 1'b0;
  longint heldData = 0;

  matvec_param #(.K(K), .IW(IW), .OW(OW)) dutA (
    .i_clk          (clk),
    .i_reset        (aReset),
    .i_input_valid  (aInputValid),
    .o_input_ready  (aInputReady),
    .i_input_data   (aInputData),
    .i_new_matrix   (aNewMatrix),
    .o_output_valid (aOutputValid),
    .i_output_ready (aOutputReady),
    .o_output_data  (aOutputData)
  );

  matvec_param dutB (
    .i_clk          (clk),
    .i_reset        (bReset),
    .i_input_valid  (bInputValid),
    .o_input_ready  (bInputReady),
    .i_input_data   (bInputData),
    .i_new_matrix   (bNewMatrix),
    .o_output_valid (bOutputValid),
    .i_output_ready (bOutputReady),
    .o_output_data  (bOutputData)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Fit an exact sum into an ow-bit signed result: clamp or wrap.
  function automatic longint fitOut(input longint s, input int ow);
    longint m;
    m = longint'(1) << ow;
`ifdef MATVEC_SAT_EN
    if (s > m / 2 - 1) return m / 2 - 1;
    if (s < -(m / 2)) return -(m / 2);
    return s;
`else
    begin
      longint v;
      v = s % m;
      if (v < 0) v += m;
      if (v >= m / 2) v -= m;
      return v;
    end
`endif
  endfunction

  // Output-ready driver: 0 = always ready, 1 = random 50%, 2 = never ready.
  initial begin
    aOutputReady = 1'b1;
    bOutputReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: aOutputReady = 1'b1;
        1: aOutputReady = 1'($urandom_range(1));
        default: aOutputReady = 1'b0;
      endcase
    end
  end

  // Monitor A: pops the scoreboard on every output transfer, checks hold
  // stability while stalled and zero data while idle.
  always @(negedge clk) begin
    if (aReset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checkOutput("stall_valid_held", longint'(aOutputValid), 1);
        checkOutput("stall_data_stable", longint'(aOutputData), heldData);
      end
      if (aOutputValid) begin
        if (aOutputReady) begin
          if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected_output: got %0d, expected no output (t=%0t)",
                     aOutputData, $time);
          end else begin
            checkOutput("y_value", longint'(aOutputData), expQ.pop_front());
          end
        end
        held     = !aOutputReady;
        heldData = longint'(aOutputData);
      end else begin
        held = 1'b0;
        checkOutput("idle_data_zero", longint'(aOutputData), 0);
      end
    end
  end

  // Monitor B: default-parameter instance, always ready.
  always @(negedge clk) begin
    if (!bReset && bOutputValid && bOutputReady) begin
      if (bQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL b_unexpected_output: got %0d, expected no output", bOutputData);
      end else begin
        checkOutput("b_y_value", longint'(bOutputData), bQ.pop_front());
      end
    end
  end

  // Present one element until it is accepted. nmVal < 0 means the
  // new_matrix flag is a don't-care and gets random garbage.
  task automatic driveElem(input int d, input int nmVal, input bit randValid);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    while (!done) begin
      aInputValid = randValid ? 1'($urandom_range(1)) : 1'b1;
      if (aInputValid) begin
        aInputData = 4'(d);
        aNewMatrix = (nmVal < 0) ? 1'($urandom_range(1)) : 1'(nmVal);
      end else begin
        aInputData = 4'($urandom);
        aNewMatrix = 1'($urandom_range(1));
      end
      done = aInputValid && aInputReady;
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 3000) begin
        checkOutput("input_accept_timeout", guard, 0);
        done = 1'b1;
      end
    end
    aInputValid = 1'b0;
    aInputData  = 4'($urandom);
    aNewMatrix  = 1'($urandom_range(1));
  endtask

  // Send one group from stimM/stimX and push the expected results.
  task automatic applyStimulus(input bit newM, input bit randValid);
    longint y;
    if (newM) begin
      for (int i = 0; i < K * K; i++) begin
        driveElem(stimM[i], (i == 0) ? 1 : -1, randValid);
        refMat[i] = stimM[i];
      end
    end
    for (int j = 0; j < K; j++) begin
      driveElem(stimX[j], (j == 0) ? 0 : -1, randValid);
    end
    for (int r = 0; r < K; r++) begin
      y = 0;
      for (int c = 0; c < K; c++) begin
        y += longint'(refMat[r*K+c]) * longint'(stimX[c]);
      end
      expQ.push_back(fitOut(y, OW));
    end
  endtask

  task automatic resetA();
    aReset      = 1'b1;
    aInputValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aReset = 1'b0;
    expQ.delete();
    for (int i = 0; i < K * K; i++) refMat[i] = 0;
    checkOutput("reset_output_valid", longint'(aOutputValid), 0);
    checkOutput("reset_output_data", longint'(aOutputData), 0);
    checkOutput("reset_input_ready", longint'(aInputReady), 1);
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (expQ.size() != 0 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("drain_queue_empty", expQ.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkNoValid(input string name);
    int seen;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (aOutputValid) seen++;
    end
    checkOutput(name, seen, 0);
  endtask

  initial begin
    int guard;
    aReset      = 1'b1;
    aInputValid = 1'b0;
    aInputData  = '0;
    aNewMatrix  = 1'b0;
    bReset      = 1'b1;
    bInputValid = 1'b0;
    bInputData  = '0;
    bNewMatrix  = 1'b0;
    @(posedge clk);
    #1;
    resetA();
    bReset = 1'b0;

    // Vector-only group straight after reset: matrix is all zero.
    stimX = '{7, 7};
    applyStimulus(1'b0, 1'b0);
    waitDrain();

    // Load M=[1,2,3,4], x=[5,6] -> 17, 39, first valid two edges later.
    stimM = '{1, 2, 3, 4};
    stimX = '{5, 6};
    applyStimulus(1'b1, 1'b0);
    checkOutput("latency_edge0", longint'(aOutputValid), 0);
    @(posedge clk);
    #1;
    checkOutput("latency_edge1", longint'(aOutputValid), 0);
    @(posedge clk);
    #1;
    checkOutput("latency_edge2", longint'(aOutputValid), 1);
    waitDrain();

    // Matrix reuse: x=[-1,1] -> 1, 1.
    stimX = '{-1, 1};
    applyStimulus(1'b0, 1'b0);
    waitDrain();

    // Most-negative operands: sum 128 exceeds the 8-bit output range.
    stimM = '{-8, -8, -8, -8};
    stimX = '{-8, -8};
    applyStimulus(1'b1, 1'b0);
    waitDrain();
    stimX = '{7, -8};
    applyStimulus(1'b0, 1'b0);
    waitDrain();

    // Reset after 4 matrix elements and x[0]; nothing may come out, and
    // the cleared matrix gives zero results for the next vector group.
    stimM = '{3, -2, 5, 1};
    for (int i = 0; i < K * K; i++) driveElem(stimM[i], (i == 0) ? 1 : -1, 1'b0);
    driveElem(6, 0, 1'b0);
    resetA();
    checkNoValid("no_valid_after_midload_reset");
    stimX = '{2, 3};
    applyStimulus(1'b0, 1'b0);
    waitDrain();

    // Reset while a result sits undelivered in DRAIN.
    readyMode = 2;
    stimM = '{1, 1, 1, 1};
    stimX = '{1, 1};
    applyStimulus(1'b1, 1'b0);
    guard = 0;
    while (!aOutputValid && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("drain_reached", longint'(aOutputValid), 1);
    repeat (3) @(posedge clk);
    #1;
    resetA();
    readyMode = 0;
    checkNoValid("no_valid_after_drain_reset");
    stimX = '{4, 5};
    applyStimulus(1'b0, 1'b0);
    waitDrain();

    // Random groups with random input_valid and output_ready.
    readyMode = 1;
    for (int g = 0; g < 1000; g++) begin
      bit newM;
      newM = (g == 0) || ($urandom_range(3) == 0);
      for (int i = 0; i < K * K; i++) stimM[i] = int'($urandom_range(15)) - 8;
      for (int j = 0; j < K; j++) stimX[j] = int'($urandom_range(15)) - 8;
      applyStimulus(newM, 1'b1);
    end
    waitDrain();
    readyMode = 0;

    // Default-parameter instance: every element is -8192.
    for (int i = 0; i < BK * BK + BK; i++) begin
      guard = 0;
      bInputValid = 1'b1;
      bInputData  = 14'(-8192);
      bNewMatrix  = (i == 0) ? 1'b1 : 1'($urandom_range(1));
      if (i == BK * BK) bNewMatrix = 1'b0;
      while (!bInputReady && guard < 200) begin
        @(posedge clk);
        #1;
        guard++;
      end
      @(posedge clk);
      #1;
    end
    bInputValid = 1'b0;
    for (int r = 0; r < BK; r++) begin
      bQ.push_back(fitOut(longint'(BK) * 8192 * 8192, BOW));
    end
    guard = 0;
    while (bQ.size() != 0 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("b_queue_empty", bQ.size(), 0);
    checkOutput("a_queue_empty", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
